// File: rtl/clk_tick_recovery.sv
// rtl/clk_tick_recovery.sv - divided-clock synchroniser, tick generator and per-channel lock monitor
//
// clk_tick_recovery_chan : one channel.
//   clk       in  master clock
//   clr_n     in  synchronous active-low reset
//   sig_in    in  divided clock, treated as asynchronous data
//   lost_clr  in  write-1-to-clear for the sticky loss flag
//   tick      out one-cycle pulse per rising edge of sig_in
//   locked    out high while the period checker is in LOCKED
//   lost      out sticky loss-of-lock flag
//
// clk_tick_recovery : three channels (dclk, segclk, gclk).
//   clk, clr_n                      master clock and synchronous active-low reset
//   dclk_in, segclk_in, gclk_in     divided clocks, asynchronous data
//   lost_clr[2:0]                   write-1-to-clear, bit0=dclk bit1=segclk bit2=gclk
//   dclk_tick, segclk_tick, gclk_tick  rising-edge ticks
//   locked[2:0], lost[2:0]          per-channel status, same bit order as lost_clr

module clk_tick_recovery_chan #(
    parameter int unsigned EXP        = 10,
    parameter int unsigned TOL        = 1,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned CNT_W      = 28
) (
    input  logic clk,
    input  logic clr_n,
    input  logic sig_in,
    input  logic lost_clr,
    output logic tick,
    output logic locked,
    output logic lost
);

    localparam int unsigned MC_W     = $clog2(LOCK_COUNT + 1);
    localparam int unsigned P_LO_INT = (EXP >= TOL) ? (EXP - TOL) : 0;
    localparam int unsigned P_HI_INT = EXP + TOL;
    localparam int unsigned TMO_INT  = 2 * EXP;

    // Bounds are held one bit wider than the counter so P = cnt+1 never wraps.
    localparam logic [CNT_W:0]   P_LO = (CNT_W + 1)'(P_LO_INT);
    localparam logic [CNT_W:0]   P_HI = (CNT_W + 1)'(P_HI_INT);
    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TMO_INT);
    localparam logic [MC_W-1:0]  MC_LAST = MC_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    logic             s1_q, s2_q, s3_q;
    logic             tick_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MC_W-1:0]  mc_q, mc_d;
    state_t           state_q, state_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;

    logic [CNT_W:0]   p_meas;
    logic             match;
    logic             timeout;
    logic             lost_set;

    // Three-flop chain: s1/s2 resolve metastability, s3 gives the previous
    // synchronised level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            s1_q   <= sig_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            tick_q <= s2_q & ~s3_q;
        end
    end

    // Counter restarts on every tick so that in the next tick cycle it holds
    // period-1; saturation keeps a dead input from wrapping back into range.
    always_comb begin
        cnt_d = cnt_q;
        if (tick_q) begin
            cnt_d = '0;
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign p_meas  = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign match   = (p_meas >= P_LO) && (p_meas <= P_HI);
    assign timeout = (cnt_q >= TMO);

    always_comb begin
        state_d  = state_q;
        mc_d     = mc_q;
        lost_set = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                // The first tick only starts a measurement window.
                if (tick_q) begin
                    state_d = ST_ACQUIRE;
                    mc_d    = '0;
                end
            end
            ST_ACQUIRE: begin
                if (tick_q) begin
                    if (match) begin
                        if (mc_q == MC_LAST) begin
                            state_d = ST_LOCKED;
                            mc_d    = '0;
                        end else begin
                            mc_d = mc_q + MC_W'(1);
                        end
                    end else begin
                        mc_d = '0;
                    end
                end else if (timeout) begin
                    state_d = ST_UNLOCKED;
                    mc_d    = '0;
                end
            end
            ST_LOCKED: begin
                if (tick_q) begin
                    if (!match) begin
                        state_d  = ST_ACQUIRE;
                        mc_d     = '0;
                        lost_set = 1'b1;
                    end
                end else if (timeout) begin
                    state_d  = ST_UNLOCKED;
                    lost_set = 1'b1;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                mc_d    = '0;
            end
        endcase
    end

    assign locked_d = (state_d == ST_LOCKED);
    // A new loss event takes priority over a clear in the same cycle.
    assign lost_d   = lost_set | (lost_q & ~lost_clr);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_q    <= '0;
            mc_q     <= '0;
            state_q  <= ST_UNLOCKED;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mc_q     <= mc_d;
            state_q  <= state_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
        end
    end

    assign tick   = tick_q;
    assign locked = locked_q;
    assign lost   = lost_q;

endmodule

module clk_tick_recovery #(
    parameter int unsigned DCLK_PERIOD   = 10,
    parameter int unsigned SEGCLK_PERIOD = 22,
    parameter int unsigned GCLK_PERIOD   = 22,
    parameter int unsigned TOL           = 1,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned CNT_W         = 28
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       dclk_in,
    input  logic       segclk_in,
    input  logic       gclk_in,
    input  logic [2:0] lost_clr,
    output logic       dclk_tick,
    output logic       segclk_tick,
    output logic       gclk_tick,
    output logic [2:0] locked,
    output logic [2:0] lost
);

    clk_tick_recovery_chan #(
        .EXP        (DCLK_PERIOD),
        .TOL        (TOL),
        .LOCK_COUNT (LOCK_COUNT),
        .CNT_W      (CNT_W)
    ) u_dclk (
        .clk      (clk),
        .clr_n    (clr_n),
        .sig_in   (dclk_in),
        .lost_clr (lost_clr[0]),
        .tick     (dclk_tick),
        .locked   (locked[0]),
        .lost     (lost[0])
    );

    clk_tick_recovery_chan #(
        .EXP        (SEGCLK_PERIOD),
        .TOL        (TOL),
        .LOCK_COUNT (LOCK_COUNT),
        .CNT_W      (CNT_W)
    ) u_segclk (
        .clk      (clk),
        .clr_n    (clr_n),
        .sig_in   (segclk_in),
        .lost_clr (lost_clr[1]),
        .tick     (segclk_tick),
        .locked   (locked[1]),
        .lost     (lost[1])
    );

    clk_tick_recovery_chan #(
        .EXP        (GCLK_PERIOD),
        .TOL        (TOL),
        .LOCK_COUNT (LOCK_COUNT),
        .CNT_W      (CNT_W)
    ) u_gclk (
        .clk      (clk),
        .clr_n    (clr_n),
        .sig_in   (gclk_in),
        .lost_clr (lost_clr[2]),
        .tick     (gclk_tick),
        .locked   (locked[2]),
        .lost     (lost[2])
    );

endmodule

// File: tb/tb_clk_tick_recovery.sv
// tb/tb_clk_tick_recovery.sv - scoreboard bench for clk_tick_recovery

module tb_clk_tick_recovery;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [2:0] gin;
    logic [2:0] lost_clr;
    logic       dclk_tick, segclk_tick, gclk_tick;
    logic [2:0] locked, lost;

    always #5 clk = ~clk;

    clk_tick_recovery dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .dclk_in     (gin[0]),
        .segclk_in   (gin[1]),
        .gclk_in     (gin[2]),
        .lost_clr    (lost_clr),
        .dclk_tick   (dclk_tick),
        .segclk_tick (segclk_tick),
        .gclk_tick   (gclk_tick),
        .locked      (locked),
        .lost        (lost)
    );

    // Observation word: {dclk_tick, segclk_tick, gclk_tick, locked[2:0], lost[2:0]}
    wire [8:0] obs = {dclk_tick, segclk_tick, gclk_tick, locked, lost};

    typedef struct {
        int         cyc;
        logic [8:0] mask;
        logic [8:0] val;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   tmo_req = 0;
    int   tmo_seen = 0;
    bit   done = 1'b0;
    bit   fin_done = 1'b0;

    // Input generators: one toggling source per channel.
    int run[3];
    int cnt_g[3];
    int cur_len[3];
    int hi_len[3];
    int lo_len[3];
    int extra[3];
    int jit[3];
    int jsel[3];
    int rise_n[3];
    int lock_at[3];

    function automatic logic [8:0] tk_m(input int i);
        return 9'h100 >> i;
    endfunction
    function automatic logic [8:0] lk_m(input int i);
        return 9'h008 << i;
    endfunction

    task automatic expect_at(input int c, input logic [8:0] m, input logic [8:0] v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.mask = m;
        e.val  = v;
        e.name = nm;
        sbq.push_back(e);
    endtask

    // Advance one clock; inputs change 1 time unit after the edge. A rising
    // input at cycle c is sampled at edge c+1, so its tick is seen in cycle c+3.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (run[i] != 0) begin
                cnt_g[i]++;
                if (cnt_g[i] >= cur_len[i]) begin
                    cnt_g[i] = 0;
                    if (gin[i]) begin
                        gin[i]     = 1'b0;
                        cur_len[i] = lo_len[i] + extra[i];
                        extra[i]   = 0;
                        if (jit[i] != 0) begin
                            cur_len[i] += (jsel[i] != 0) ? 1 : -1;
                            jsel[i] = (jsel[i] != 0) ? 0 : 1;
                        end
                    end else begin
                        gin[i]     = 1'b1;
                        cur_len[i] = hi_len[i];
                        rise_n[i]++;
                        expect_at(cyc + 3, tk_m(i), tk_m(i), "tick");
                        expect_at(cyc + 4, tk_m(i), 9'h000, "tick_single");
                        if (rise_n[i] == lock_at[i]) begin
                            expect_at(cyc + 3, lk_m(i), 9'h000, "pre_lock");
                            expect_at(cyc + 4, lk_m(i), lk_m(i), "lock");
                        end
                    end
                end
            end
        end
    endtask

    task automatic start_chan(input int i);
        run[i]     = 1;
        cnt_g[i]   = 0;
        cur_len[i] = gin[i] ? hi_len[i] : lo_len[i];
    endtask

    task automatic wait_rise(input int i);
        int base;
        base = rise_n[i];
        for (int k = 0; k < 100; k++) begin
            step();
            if (rise_n[i] != base) return;
        end
        tmo_req++;
    endtask

    // Monitor: pops every expectation due in this cycle and compares.
    always @(negedge clk) begin
        for (int k = sbq.size() - 1; k >= 0; k--) begin
            if (sbq[k].cyc <= cyc) begin
                n_chk++;
                if (sbq[k].cyc < cyc || (obs & sbq[k].mask) !== sbq[k].val) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %b, want %b (mask %b)",
                             sbq[k].name, sbq[k].cyc, obs & sbq[k].mask, sbq[k].val, sbq[k].mask);
                end
                sbq.delete(k);
            end
        end
        if (tmo_req != tmo_seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_timeout @cyc %0d: got no input edge, want one", cyc);
            tmo_seen = tmo_req;
        end
        if (done && !fin_done) begin
            fin_done = 1'b1;
            n_chk++;
            if (sbq.size() != 0) begin
                n_fail++;
                $display("FAIL pending_checks: got %0d left, want 0", sbq.size());
            end
        end
    end

    initial begin
        int r;
        clr_n    = 1'b0;
        gin      = 3'b000;
        lost_clr = 3'b000;
        hi_len   = '{5, 11, 11};
        lo_len   = '{5, 11, 11};
        for (int i = 0; i < 3; i++) begin
            run[i] = 0; cnt_g[i] = 0; cur_len[i] = 0; extra[i] = 0;
            jit[i] = 0; jsel[i] = 0; rise_n[i] = 0; lock_at[i] = -1;
        end

        // Reset state
        repeat (3) step();
        expect_at(cyc + 1, 9'h1FF, 9'h000, "reset_state");
        repeat (2) step();

        // 1: default divider outputs, all three lock after their 5th tick
        clr_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lock_at[i] = rise_n[i] + 5;
            start_chan(i);
        end
        repeat (130) step();
        expect_at(cyc + 1, 9'h03F, 9'h038, "t1_all_locked");
        step();

        // 2: dclk held static -> timeout about 20 cycles after the last tick
        wait_rise(0);
        run[0] = 0;
        r = cyc + 3;
        expect_at(r + 19, 9'h009, 9'h008, "t2_still_locked");
        expect_at(r + 23, 9'h009, 9'h001, "t2_timeout_lost");
        expect_at(r + 23, 9'h036, 9'h030, "t2_others_ok");
        repeat (30) step();

        // 3: relock, clear, then one 12-cycle period while locked
        lock_at[0] = rise_n[0] + 5;
        start_chan(0);
        repeat (70) step();
        expect_at(cyc + 1, 9'h009, 9'h009, "t3_relock_lost_sticky");
        step();
        lost_clr = 3'b001;
        expect_at(cyc + 1, 9'h001, 9'h000, "t3_clear");
        step();
        lost_clr = 3'b000;
        wait_rise(0);
        extra[0] = 2;
        wait_rise(0);
        r = cyc;
        expect_at(r + 3, 9'h009, 9'h008, "t3_pre_mismatch");
        expect_at(r + 4, 9'h009, 9'h001, "t3_mismatch_lost");
        lock_at[0] = rise_n[0] + 4;
        repeat (50) step();
        expect_at(cyc + 1, 9'h009, 9'h009, "t3_relock_lost_held");
        step();

        // 4: clear in the same cycle as an 8-cycle period mismatch
        wait_rise(0);
        extra[0] = -2;
        wait_rise(0);
        r = cyc;
        expect_at(r + 3, 9'h009, 9'h009, "t4_pre_event");
        expect_at(r + 4, 9'h009, 9'h001, "t4_set_wins");
        lock_at[0] = rise_n[0] + 4;
        repeat (3) step();
        lost_clr = 3'b001;
        step();
        lost_clr = 3'b000;
        repeat (4) step();
        expect_at(cyc + 1, 9'h001, 9'h001, "t4_still_set");
        step();
        lost_clr = 3'b001;
        expect_at(cyc + 1, 9'h001, 9'h000, "t4_later_clear");
        step();
        lost_clr = 3'b000;
        repeat (60) step();

        // 6: one-cycle reset while locked
        for (int i = 0; i < 3; i++) run[i] = 0;
        repeat (5) step();
        gin = 3'b000;
        repeat (2) step();
        expect_at(cyc + 1, 9'h03F, 9'h038, "t6_pre_reset");
        step();
        clr_n = 1'b0;
        expect_at(cyc + 1, 9'h1FF, 9'h000, "t6_reset_clears");
        step();
        clr_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lock_at[i] = rise_n[i] + 5;
            start_chan(i);
        end
        repeat (130) step();
        expect_at(cyc + 1, 9'h03F, 9'h038, "t6_relocked");
        step();

        // 5: dclk high at reset release, then 9/11 cycle periods
        for (int i = 0; i < 3; i++) run[i] = 0;
        repeat (5) step();
        gin      = 3'b000;
        clr_n    = 1'b0;
        gin[0]   = 1'b1;
        repeat (2) step();
        clr_n = 1'b1;
        r = cyc;
        expect_at(r + 3, tk_m(0), tk_m(0), "t5_release_tick");
        expect_at(r + 4, tk_m(0), 9'h000, "t5_release_single");
        expect_at(r + 20, 9'h009, 9'h000, "t5_no_false_lock");
        lock_at[0] = rise_n[0] + 4;
        jit[0]  = 1;
        jsel[0] = 0;
        start_chan(0);
        repeat (60) step();
        expect_at(cyc + 1, 9'h03F, 9'h008, "t5_locked_jitter");
        repeat (6) step();

        done = 1'b1;
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
